// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall and forward selects from an EX/MEM/WB scoreboard.
// Define HAZARD_MDU_STALL_EN to add the mult/div busy counter and its HI/LO stall.
package hazard_ctrl_pkg;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned T_W      = 2;
  localparam int unsigned RES_W    = 2;
  localparam int unsigned FWD_W    = 3;
  localparam int unsigned MD_CNT_W = 4;

  localparam logic [RES_W-1:0] RES_NONE = RES_W'(0);
  localparam logic [RES_W-1:0] RES_ALU  = RES_W'(1);
  localparam logic [RES_W-1:0] RES_MEM  = RES_W'(2);
  localparam logic [RES_W-1:0] RES_PC8  = RES_W'(3);

  localparam logic [FWD_W-1:0] FWD_GRF     = FWD_W'(0);
  localparam logic [FWD_W-1:0] FWD_ALU_MEM = FWD_W'(1);
  localparam logic [FWD_W-1:0] FWD_MDM_MEM = FWD_W'(2);
  localparam logic [FWD_W-1:0] FWD_WD_WB   = FWD_W'(3);
  localparam logic [FWD_W-1:0] FWD_PC8_EX  = FWD_W'(4);
  localparam logic [FWD_W-1:0] FWD_PC8_MEM = FWD_W'(5);
  localparam logic [FWD_W-1:0] FWD_PC8_WB  = FWD_W'(6);

  localparam logic [MD_CNT_W-1:0] MD_MULT_CYC = MD_CNT_W'(5);
  localparam logic [MD_CNT_W-1:0] MD_DIV_CYC  = MD_CNT_W'(10);

  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic [T_W-1:0]   tnew;
    logic [RES_W-1:0] res;
  } stage_t;

  typedef struct packed {
    logic             stall;
    logic [FWD_W-1:0] fwd;
  } src_dec_t;

  localparam stage_t BUBBLE = '0;
endpackage

module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_ID,
  input  logic [REG_W-1:0] rt_ID,
  input  logic [T_W-1:0]   tuse_rs_ID,
  input  logic [T_W-1:0]   tuse_rt_ID,
  input  logic [REG_W-1:0] dst_ID,
  input  logic [T_W-1:0]   tnew_ID,
  input  logic [RES_W-1:0] res_ID,
  input  logic             md_start_ID,
  input  logic             md_div_ID,
  input  logic             md_use_ID,
  output logic [FWD_W-1:0] fwd_rs_ID,
  output logic [FWD_W-1:0] fwd_rt_ID,
  output logic             stall,
  output logic             md_busy
);

  stage_t   ex_q, mem_q, wb_q;
  stage_t   id_entry;
  src_dec_t rs_dec, rt_dec;
  logic     md_hazard;

  // A bubble or a no-result instruction never produces a match
  function automatic logic entry_hit(input stage_t e, input logic [REG_W-1:0] src);
    return (src != '0) && (e.dst == src) && (e.res != RES_NONE);
  endfunction

  function automatic stage_t age_entry(input stage_t e);
    stage_t a;
    a = e;
    if (e.tnew != '0) a.tnew = e.tnew - T_W'(1);
    return a;
  endfunction

  // Youngest matching entry decides; a result not yet ready either stalls or reads GRF
  function automatic src_dec_t resolve(input logic [REG_W-1:0] src,
                                       input logic [T_W-1:0]   tuse,
                                       input stage_t           ex,
                                       input stage_t           mem,
                                       input stage_t           wb);
    src_dec_t r;
    r = '0;
    if (entry_hit(ex, src)) begin
      if (ex.tnew > tuse) r.stall = 1'b1;
      else if ((ex.tnew == '0) && (ex.res == RES_PC8)) r.fwd = FWD_PC8_EX;
    end else if (entry_hit(mem, src)) begin
      if (mem.tnew > tuse) r.stall = 1'b1;
      else if (mem.tnew == '0) begin
        case (mem.res)
          RES_ALU: r.fwd = FWD_ALU_MEM;
          RES_MEM: r.fwd = FWD_MDM_MEM;
          RES_PC8: r.fwd = FWD_PC8_MEM;
          default: r.fwd = FWD_GRF;
        endcase
      end
    end else if (entry_hit(wb, src)) begin
      if (wb.tnew > tuse) r.stall = 1'b1;
      else if (wb.tnew == '0) r.fwd = (wb.res == RES_PC8) ? FWD_PC8_WB : FWD_WD_WB;
    end
    return r;
  endfunction

  always_comb begin
    id_entry      = BUBBLE;
    id_entry.dst  = dst_ID;
    id_entry.tnew = tnew_ID;
    id_entry.res  = res_ID;
  end

  always_comb begin
    rs_dec = resolve(rs_ID, tuse_rs_ID, ex_q, mem_q, wb_q);
    rt_dec = resolve(rt_ID, tuse_rt_ID, ex_q, mem_q, wb_q);
  end

  assign stall     = rs_dec.stall | rt_dec.stall | md_hazard;
  assign fwd_rs_ID = rs_dec.fwd;
  assign fwd_rt_ID = rt_dec.fwd;

  // Scoreboard advance; a stalled ID instruction is replaced by a bubble in EX
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      ex_q  <= stall ? BUBBLE : id_entry;
      mem_q <= age_entry(ex_q);
      wb_q  <= age_entry(mem_q);
    end
  end

`ifdef HAZARD_MDU_STALL_EN
  logic [MD_CNT_W-1:0] md_cnt_q;
  logic                ex_md_q;
  logic                md_issue;

  assign md_issue = md_start_ID & ~stall;

  // Counter loads on the issuing edge, so ex_md_q only covers the issue cycle itself
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= '0;
      ex_md_q  <= 1'b0;
    end else begin
      ex_md_q <= md_issue;
      if (md_issue) md_cnt_q <= md_div_ID ? MD_DIV_CYC : MD_MULT_CYC;
      else if (md_cnt_q != '0) md_cnt_q <= md_cnt_q - MD_CNT_W'(1);
    end
  end

  assign md_busy   = (md_cnt_q != '0);
  assign md_hazard = md_use_ID & (md_busy | (ex_md_q & (md_cnt_q == '0)));
`else
  logic unused_md;

  assign unused_md = ^{md_start_ID, md_div_ID, md_use_ID};
  assign md_busy   = 1'b0;
  assign md_hazard = 1'b0;
`endif

endmodule
